demo_uart_tx: RTL and testbench
===============================

// Module: demo_uart_tx
// PURPOSE
//   Downstream consumer of the demo counter's 8-bit output stream. Takes one byte per
//   valid/ready handshake and serialises it as an 8N1/8N2 UART frame on tx (LSB first).
//   Sits between the demo datapath and the board UART pin; single clock domain.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range >= 2
//   STOP_BITS     1    number of stop bits; legal values 1 or 2
//   PARITY_ODD    0    0 = even parity, 1 = odd; used only with DEMO_UART_PARITY_EN
// PORTS
//   clk       in   1  system clock; all state on rising edge
//   reset     in   1  asynchronous, active-low reset (0 = in reset)
//   in_data   in   8  byte to transmit; sampled on the accept cycle only
//   in_valid  in   1  in_data holds a byte to send
//   in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready
//   tx        out  1  UART serial line; idle high
//   busy      out  1  high from the cycle after accept to the end of the last stop bit
//   tx_done   out  1  one-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//   - Reset (reset=0, async): tx=1, in_ready=0, busy=0, tx_done=0, state=IDLE,
//     bit/baud counters=0. in_ready rises at the first clk edge after reset deasserts.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     IDLE:   tx=1, in_ready=1. On accept: latch in_data into shift reg, go START.
//     START:  tx=0 for CLKS_PER_BIT cycles.
//     DATA:   tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; 8 bits, bit 0 first.
//     PARITY: present only with DEMO_UART_PARITY_EN; one bit time.
//     STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 in the final cycle;
//             next state IDLE.
//   - in_ready is registered, =1 only in IDLE (after reset); 0 in all other states.
//   - Latency: the start bit begins on the cycle after the accept edge.
//   - Frame length: (10 + parity + STOP_BITS-1) * CLKS_PER_BIT cycles.
//   - Back-to-back: with in_valid held high, exactly one IDLE cycle between frames.
//     Start-to-start spacing = frame length + 1 cycle.
//   - Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0
//     and advances the bit index. It never free-runs in IDLE (held at 0).
//   - Input changes during a frame (in_data/in_valid) have no effect; the latched byte is sent.
//   - Reset mid-frame: frame aborted, tx=1 immediately, no tx_done. The partial byte is
//     discarded and not re-sent after reset.
//   - Out-of-range parameters (CLKS_PER_BIT<2, STOP_BITS not 1/2) cause $fatal at elaboration.
// CONFIGURATION
//   DEMO_UART_PARITY_EN defined:
//     - PARITY state inserted after DATA.
//     - tx = ^byte ^ PARITY_ODD for one bit time.
//     - Frame grows by CLKS_PER_BIT.
//   DEMO_UART_PARITY_EN undefined:
//     - No PARITY state or logic; PARITY_ODD is ignored.
//     - Frame is 8N1/8N2.
// TESTING  (CLKS_PER_BIT=4, STOP_BITS=1, 10 ns clk unless noted)
//   1 Hold reset=0 for 20 ns -> tx=1, in_ready=0, busy=0, tx_done=0.
//     Release -> in_ready=1 after the first edge.
//   2 Send 0xA5 -> tx sampled mid-bit = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop).
//     busy high 40 cycles; one tx_done pulse in cycle 40.
//   3 in_valid held, 0x00 then 0xFF -> second start bit falls 41 cycles after the first.
//     Both frames correct; two tx_done pulses.
//   4 Change in_data to 0x3C mid-frame of 0xA5 with in_valid=1 -> in_ready=0; 0xA5 sent intact.
//     0x3C accepted in the following IDLE cycle.
//   5 Assert reset during data bit 3 -> tx=1 within same cycle (async), no tx_done.
//     After release, 0x5A transmits correctly.
//   6 With DEMO_UART_PARITY_EN, send 0xA5 -> parity bit 0 (PARITY_ODD=0) or 1 (PARITY_ODD=1).
//     Frame 44 cycles; tx_done in cycle 44.

Source files
------------

// File: rtl/demo_uart_tx.sv
// Byte-stream to UART serialiser: 8 data bits LSB first, 1 or 2 stop bits, valid/ready input.
// Optional parity bit after the data bits when DEMO_UART_PARITY_EN is defined.
module demo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "demo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "demo_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $fatal(1, "demo_uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DEMO_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state, next_state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            bit_end;
  logic            accept;

`ifdef DEMO_UART_PARITY_EN
  logic            par_bit;
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign accept  = (state == S_IDLE) && in_valid && in_ready;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      // Registered ready: high exactly while the next state is IDLE.
      in_ready <= (next_state == S_IDLE);
      if (state == S_IDLE || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BW'(1);
      if (next_state != state)
        bit_cnt <= '0;
      else if (bit_end)
        bit_cnt <= bit_cnt + 3'd1;
      if (accept)
        shift <= in_data;
      else if (state == S_DATA && bit_end)
        shift <= {1'b0, shift[7:1]};
    end
  end

`ifdef DEMO_UART_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      par_bit <= 1'b0;
    else if (accept)
      par_bit <= (^in_data) ^ PARITY_ODD[0];
  end
`endif

  always_comb begin
    next_state = state;
    tx         = 1'b1;
    tx_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept)
          next_state = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end)
          next_state = S_DATA;
      end
      S_DATA: begin
        tx = shift[0];
        if (bit_end && bit_cnt == 3'd7)
`ifdef DEMO_UART_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
      end
`ifdef DEMO_UART_PARITY_EN
      S_PARITY: begin
        tx = par_bit;
        if (bit_end)
          next_state = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end && bit_cnt == STOP_LAST) begin
          tx_done    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_demo_uart_tx.sv
// Directed bench for demo_uart_tx at CLKS_PER_BIT=4, STOP_BITS=1, 10 ns clock.
module tb_demo_uart_tx;

  localparam int CPB        = 4;
  localparam int PARITY_ODD = 0;
`ifdef DEMO_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  demo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1),
    .PARITY_ODD  (PARITY_ODD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Entered in frame cycle 1 (just after the accept edge); leaves in the IDLE cycle after the frame.
  task automatic run_frame(input logic [7:0] b, input logic [7:0] nd, input logic nv, input string tag);
    logic [11:0] exp_bits;
    int busy_n, done_n, done_at;
    busy_n   = 0;
    done_n   = 0;
    done_at  = 0;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef DEMO_UART_PARITY_EN
    exp_bits[9] = (^b) ^ PARITY_ODD[0];
`endif
    for (int c = 1; c <= FRAME; c++) begin
      if (c == 2) begin
        chk({tag, ".ready_low"}, 32'(in_ready), 0);
        in_data  = nd;
        in_valid = nv;
      end
      if (c % CPB == 3)
        chk($sformatf("%s.bit%0d", tag, c / CPB), 32'(tx), 32'(exp_bits[c / CPB]));
      if (busy) busy_n++;
      if (tx_done) begin
        done_n++;
        done_at = c;
      end
      step();
    end
    chk({tag, ".busy_cycles"}, busy_n, FRAME);
    chk({tag, ".done_count"}, done_n, 1);
    chk({tag, ".done_cycle"}, done_at, FRAME);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    chk({tag, ".idle_tx"}, 32'(tx), 1);
    chk({tag, ".idle_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int start0, low_n;
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset state
    #12;
    chk("rst.tx", 32'(tx), 1);
    chk("rst.ready", 32'(in_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(tx_done), 0);
    #8 reset = 1'b1;
    #1 chk("rel.ready_before_edge", 32'(in_ready), 0);
    step();
    chk("rel.ready", 32'(in_ready), 1);
    chk("rel.tx", 32'(tx), 1);

    // Single frame 0xA5
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    chk("a5.start_latency", 32'(tx), 0);
    run_frame(8'hA5, 8'h00, 1'b0, "a5");

    // Back-to-back 0x00 then 0xFF with in_valid held
    in_data  = 8'h00;
    in_valid = 1'b1;
    step();
    start0 = cyc;
    run_frame(8'h00, 8'hFF, 1'b1, "b2b0");
    step();
    chk("b2b.spacing", cyc - start0, FRAME + 1);
    chk("b2b.start_tx", 32'(tx), 0);
    run_frame(8'hFF, 8'hA5, 1'b1, "b2b1");

    // 0xA5 with in_data switched to 0x3C mid-frame
    step();
    run_frame(8'hA5, 8'h3C, 1'b1, "hold");
    step();
    chk("hold.next_busy", 32'(busy), 1);
    run_frame(8'h3C, 8'h00, 1'b0, "next3c");

    // Reset during data bit 3 of 0xC3
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("abort.pre_tx", 32'(tx), 0);
    #2 reset = 1'b0;
    #1;
    chk("abort.tx", 32'(tx), 1);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.ready", 32'(in_ready), 0);
    chk("abort.done", 32'(tx_done), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort.hold_done", 32'(tx_done), 0);
    end
    #2 reset = 1'b1;
    step();
    chk("abort.ready_after", 32'(in_ready), 1);
    low_n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!tx || busy || tx_done) low_n++;
      step();
    end
    chk("abort.no_resend", low_n, 0);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    step();
    run_frame(8'h5A, 8'h00, 1'b0, "post5a");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
